// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period in clock cycles, publishes matched pairs, flags signal loss.
// Optional glitch filter after the synchronizer is enabled with `define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
   parameter int unsigned TIMEOUT_CYCLES = 4000000,
   parameter int unsigned FILTER_LEN     = 4
) (
   input  logic        clock_clk,
   input  logic        reset_reset,
   input  logic        pwm_in,
   input  logic        ack,
   output logic [31:0] pulse_width,
   output logic [31:0] period,
   output logic        data_valid,
   output logic        new_data,
   output logic        timeout
);

   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_WAIT_RISE,
      ST_HIGH,
      ST_LOW
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_width_tmp;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_s_d;
   logic             w_s;
   logic             w_rise;
   logic             w_fall;

   // Two-flop synchronizer for the asynchronous input
   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic           r_filt;
   logic [FCW-1:0] r_fcnt;

   // Output follows the input only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         r_filt <= 1'b0;
         r_fcnt <= '0;
      end else if (r_sync2 != r_filt) begin
         if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync2;
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + FCW'(1);
         end
      end else begin
         r_fcnt <= '0;
      end
   end

   assign w_s = r_filt;
`else
   logic w_unused_filter_len;

   assign w_unused_filter_len = ^32'(FILTER_LEN);
   assign w_s                 = r_sync2;
`endif

   assign w_rise = w_s & ~r_s_d;
   assign w_fall = ~w_s & r_s_d;

   // Measurement FSM, counter and registered outputs
   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         r_state     <= ST_WAIT_RISE;
         r_cnt       <= '0;
         r_width_tmp <= '0;
         r_s_d       <= 1'b0;
         pulse_width <= '0;
         period      <= '0;
         data_valid  <= 1'b0;
         new_data    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         r_s_d      <= w_s;
         data_valid <= 1'b0;

         if (w_rise) begin
            r_cnt <= CNT_W'(1);
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (ack) begin
            new_data <= 1'b0;
         end

         case (r_state)
            ST_WAIT_RISE: begin
               if (w_rise) begin
                  r_state <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (w_fall) begin
                  r_width_tmp <= r_cnt;
                  r_state     <= ST_LOW;
               end else if (r_cnt == TO_CNT) begin
                  timeout <= 1'b1;
                  r_state <= ST_WAIT_RISE;
               end
            end
            ST_LOW: begin
               // A publish overrides a same-cycle ack so the new pair is never lost
               if (w_rise) begin
                  pulse_width <= r_width_tmp;
                  period      <= r_cnt;
                  data_valid  <= 1'b1;
                  new_data    <= 1'b1;
                  timeout     <= 1'b0;
                  r_state     <= ST_HIGH;
               end else if (r_cnt == TO_CNT) begin
                  timeout <= 1'b1;
                  r_state <= ST_WAIT_RISE;
               end
            end
            default: begin
               r_state <= ST_WAIT_RISE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (TIMEOUT_CYCLES=50, FILTER_LEN=4).
module tb_pwm_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm;
   logic        ack;
   logic [31:0] pulse_width;
   logic [31:0] period;
   logic        data_valid;
   logic        new_data;
   logic        timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] q_w[$];
   logic [31:0] q_p[$];
   int          q_c[$];

   pwm_capture #(
      .TIMEOUT_CYCLES(50),
      .FILTER_LEN    (4)
   ) dut (
      .clock_clk  (clk),
      .reset_reset(rst),
      .pwm_in     (pwm),
      .ack        (ack),
      .pulse_width(pulse_width),
      .period     (period),
      .data_valid (data_valid),
      .new_data   (new_data),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every publish with the edge count at which it became visible
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         q_w.push_back(pulse_width);
         q_p.push_back(period);
         q_c.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         pwm = 1'b1;
         repeat (hi) step();
         pwm = 1'b0;
         repeat (lo) step();
      end
   endtask

   task automatic clear_log();
      q_w.delete();
      q_p.delete();
      q_c.delete();
   endtask

   function automatic logic [63:0] qw(input int i);
      return (i < q_w.size()) ? 64'(q_w[i]) : '1;
   endfunction

   function automatic logic [63:0] qp(input int i);
      return (i < q_p.size()) ? 64'(q_p[i]) : '1;
   endfunction

   function automatic logic [63:0] qc(input int i);
      return (i < q_c.size()) ? 64'(q_c[i]) : '1;
   endfunction

   initial begin
      int a0;
      int t0;
      int bad;

      rst = 1'b1;
      pwm = 1'b0;
      ack = 1'b0;
      repeat (3) step();
      check("rst_width",    pulse_width, 0);
      check("rst_period",   period,      0);
      check("rst_valid",    data_valid,  0);
      check("rst_new_data", new_data,    0);
      check("rst_timeout",  timeout,     0);
      rst = 1'b0;

      // Constant input from reset never arms and never times out
      repeat (60) step();
      check("idle_timeout", timeout,        0);
      check("idle_publish", 64'(q_w.size()), 0);

`ifdef PWM_CAPTURE_FILTER_EN
      // Clean 6/14: first publish at second rise, 7 edges of latency
      t0 = cyc;
      wave(6, 14, 3);
      check("F_count",    64'(q_w.size()), 2);
      check("F_w",        qw(0), 6);
      check("F_p",        qp(0), 20);
      check("F_first_dv", qc(0), 64'(t0 + 27));

      // Short spike inside the low phase is swallowed
      clear_log();
      wave(6, 6, 1); wave(2, 6, 1);
      wave(6, 6, 1); wave(2, 6, 1);
      wave(6, 14, 1);
      check("F_spike_count", 64'(q_w.size()), 3);
      bad = 0;
      for (int i = 0; i < q_w.size(); i++) if (q_w[i] !== 6 || q_p[i] !== 20) bad++;
      check("F_spike_pairs", 64'(bad), 0);

      // 2-cycle dropout inside a high pulse is bridged
      clear_log();
      wave(4, 2, 1); wave(2, 12, 1);
      wave(6, 14, 1);
      check("F_drop_count", 64'(q_w.size()), 2);
      check("F_drop_w",     qw(1), 8);
      check("F_drop_p",     qp(1), 20);

      // 5-cycle dropout is long enough to count as real edges
      clear_log();
      wave(4, 5, 1); wave(4, 7, 1);
      wave(6, 14, 1);
      check("F_real_count", 64'(q_w.size()), 3);
      check("F_real_w1",    qw(1), 4);
      check("F_real_p1",    qp(1), 9);
      check("F_real_w2",    qw(2), 4);
      check("F_real_p2",    qp(2), 11);
`else
      // 3 high / 7 low: publish at second rise, 3 edges after the driven rise
      a0 = cyc;
      wave(3, 7, 4);
      check("A_count",     64'(q_w.size()), 3);
      check("A_w",         qw(2), 3);
      check("A_p",         qp(2), 10);
      check("A_first_dv",  qc(0), 64'(a0 + 13));
      check("A_second_dv", qc(1), 64'(a0 + 23));
      check("A_new_data",  new_data, 1);
      check("A_timeout",   timeout,  0);

      // Switch to 9/1: each publish is a whole pair from one period
      clear_log();
      wave(9, 1, 3);
      check("B_count", 64'(q_w.size()), 3);
      check("B_w0",    qw(0), 3);
      check("B_w1",    qw(1), 9);
      check("B_w2",    qw(2), 9);
      bad = 0;
      for (int i = 0; i < q_p.size(); i++) if (q_p[i] !== 10) bad++;
      check("B_periods", 64'(bad), 0);

      // Plain ack clears new_data
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("ack_clear", new_data,   0);
      check("ack_valid", data_valid, 0);

      // Ack coinciding with a publish: publish wins
      pwm = 1'b1;
      t0  = cyc;
      step();
      step();
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("ackpub_valid",    data_valid,  1);
      check("ackpub_new_data", new_data,    1);
      check("ackpub_w",        pulse_width, 9);
      check("ackpub_p",        period,      11);
      step();
      check("ackpub_strobe",   data_valid,  0);
      check("ackpub_sticky",   new_data,    1);

      // Stuck high: timeout the edge after cnt reaches 50
      while (cyc < t0 + 52) step();
      check("to_before", timeout, 0);
      step();
      check("to_set",    timeout,     1);
      check("to_hold_w", pulse_width, 9);
      check("to_hold_p", period,      11);

      // Recovery: first rise only arms, second publishes and clears timeout
      pwm = 1'b0;
      repeat (7) step();
      clear_log();
      wave(3, 7, 1);
      check("rec_arm_count", 64'(q_w.size()), 0);
      check("rec_arm_to",    timeout,         1);
      wave(3, 7, 1);
      check("rec_count", 64'(q_w.size()), 1);
      check("rec_w",     qw(0), 3);
      check("rec_p",     qp(0), 10);
      check("rec_to",    timeout, 0);

      // Reset in the middle of a high phase
      pwm = 1'b1;
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      pwm = 1'b0;
      check("mid_rst_w",     pulse_width, 0);
      check("mid_rst_p",     period,      0);
      check("mid_rst_valid", data_valid,  0);
      check("mid_rst_new",   new_data,    0);
      check("mid_rst_to",    timeout,     0);
      repeat (4) step();
      clear_log();
      wave(3, 7, 1);
      check("mid_rst_arm", 64'(q_w.size()), 0);
      wave(3, 7, 1);
      check("mid_rst_count", 64'(q_w.size()), 1);
      check("mid_rst_pw",    qw(0), 3);
      check("mid_rst_pp",    qp(0), 10);

      // Fastest input: 1 high / 1 low
      wave(1, 1, 5);
      clear_log();
      wave(1, 1, 4);
      check("fast_count", 64'(q_w.size()), 4);
      check("fast_w",     qw(3), 1);
      check("fast_p",     qp(3), 2);
      bad = 0;
      for (int i = 0; i < q_w.size(); i++) if (q_w[i] !== 1 || q_p[i] !== 2) bad++;
      check("fast_pairs", 64'(bad), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the high time and period of an incoming PWM signal, such as servo feedback or an RC receiver channel, in system-clock cycles. It publishes each completed period as a coherent width/period pair to the register interface. It is the receive-side counterpart of the servo PWM generator and uses the same count domain, so a measured `pulse_width` can be written straight back as a generator `pulseTime`. It also detects loss of signal.

## Interface
- `TIMEOUT_CYCLES`, default 4000000: cycles without a required edge before declaring signal loss (2 servo frames).
- `FILTER_LEN`, default 4: consecutive stable samples required by the glitch filter (only used with the filter macro).
- `clock_clk`, input, 1: system clock; all logic on its rising edge.
- `reset_reset`, input, 1: synchronous, active-high reset.
- `pwm_in`, input, 1: asynchronous PWM input.
- `ack`, input, 1: consumer acknowledge; clears `new_data`.
- `pulse_width`, output, 32: high time of the last complete period, in cycles.
- `period`, output, 32: rising-to-rising time of the last complete period, in cycles.
- `data_valid`, output, 1: one-cycle strobe when `pulse_width`/`period` update.
- `new_data`, output, 1: sticky flag; set with `data_valid`, cleared by `ack`.
- `timeout`, output, 1: sticky signal-loss flag.

## Operation
- `pwm_in` passes through a 2-flop synchronizer and becomes `s`. Edge detection compares `s` with its previous value: a rise is `s & ~s_d`, a fall is `~s & s_d`.
- One 32-bit counter `cnt`:
  - loads 1 in the cycle after a rise;
  - otherwise increments;
  - saturates at 2^32-1.
- States:
  - **WAIT_RISE** (reset state): no reference edge yet.
    - On a rise, go to HIGH and set `cnt`=1.
  - **HIGH**:
    - On a fall, latch `width_tmp` = `cnt` and go to LOW.
    - If `cnt` == `TIMEOUT_CYCLES` with no fall, set `timeout`=1 and go to WAIT_RISE.
  - **LOW**:
    - On a rise, set `pulse_width` = `width_tmp`, `period` = `cnt`, `data_valid`=1, `new_data`=1, `timeout`=0, `cnt`=1, and go to HIGH.
    - If `cnt` == `TIMEOUT_CYCLES` with no rise, set `timeout`=1 and go to WAIT_RISE.
- `pulse_width` and `period` change only on publish and are always a matched pair. On timeout they hold their last values.
- `new_data`/`ack` priority:
  - If `ack` and publish occur in the same cycle, publish wins and `new_data` stays 1.
  - `ack` while `new_data`=0 has no effect.
- The first rise after reset or after a timeout only arms the block. The first publish is at the second rise.
- The counter is never compared against 0, so a 1-cycle-high or 1-cycle-low input is measured correctly (width 1, or width = period-1).

## Timing
- Reset values: `pulse_width`=0, `period`=0, `data_valid`=0, `new_data`=0, `timeout`=0, state=WAIT_RISE, `cnt`=0. Synchronizer flops reset to 0.
- Reset asserted mid-measurement abandons the period. Nothing is published from a partial period.
- Input-to-`s` latency is 2 cycles. With the filter macro it is 2+`FILTER_LEN` cycles; the filter adds the same delay to both edges, so widths are unchanged.
- Outputs are registered. `data_valid` is high the cycle after the synchronized rise that closes a period, for exactly one cycle.
- Measured width = (fall cycle - rise cycle) of `s`. Period = (rise2 - rise1) of `s`.
- `timeout` asserts the cycle after `cnt` reaches `TIMEOUT_CYCLES`.
  - Stuck-high input: timeout at `TIMEOUT_CYCLES` after the rise.
  - Stuck-low input: timeout at `TIMEOUT_CYCLES` after the last rise.
- A signal held constant from reset never leaves WAIT_RISE and never asserts `timeout`.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined:
  - Insert a glitch filter after the synchronizer. Filtered `s` changes only after the raw synchronized input has differed from it for `FILTER_LEN` consecutive cycles.
  - Pulses shorter than `FILTER_LEN` cycles are ignored: no edge, no count reset.
- Not defined: the filter is absent, `s` is the synchronizer output directly, and `FILTER_LEN` is unused.

## Test plan
- Reset, then drive `pwm_in` 3 cycles high / 7 cycles low repeatedly. The first `data_valid` comes one period after the first rise, with `pulse_width`=3 and `period`=10. Every following period gives the same values, and `data_valid` is high one cycle per period.
- Change the input to 9 high / 1 low. The next publish shows `pulse_width`=9, `period`=10 with no intermediate mixed pair. Then `ack`: `new_data` clears. Then `ack` on the same cycle as a publish: `new_data` stays 1.
- With `TIMEOUT_CYCLES`=50, hold `pwm_in` high after a valid period. `timeout`=1 exactly 50 cycles after the rise, and the outputs hold their previous values. Restore 3/7: the first rise produces no publish, the second rise publishes 3/10 and clears `timeout`.
- Assert `reset_reset` for 1 cycle mid-HIGH. All outputs are at reset values the next cycle, and the first publish comes only after two fresh rises.
- With `PWM_CAPTURE_FILTER_EN` and `FILTER_LEN`=4, inject a 2-cycle low glitch inside a 6-high/14-low waveform. It is ignored and the block publishes 6/20. A 5-cycle glitch is measured as real edges.
- Drive 1 high / 1 low. The block publishes `pulse_width`=1, `period`=2.
